// File: rtl/life_pkg.sv
// Shared constants for the life control slice: FSM state encoding, key indices, scan widths.
// Pure definitions; no timing, no backpressure.
package life_pkg;
   localparam int DEF_LOG2X = 3;
   localparam int DEF_LOG2Y = 3;
   localparam int CNT_W     = DEF_LOG2X + DEF_LOG2Y;

   localparam int NUM_KEYS  = 6;
   localparam int KEY_FLIP  = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_UP    = 2;
   localparam int KEY_LEFT  = 3;
   localparam int KEY_RIGHT = 4;
   localparam int KEY_RUN   = 5;

   typedef enum logic [1:0] {
      EDIT = 2'd0,
      ARM  = 2'd1,
      PASS = 2'd2,
      GAP  = 2'd3
   } state_t;
endpackage

// File: rtl/life_debounce.sv
// Synchronises and debounces N active-low buttons into one-clock press pulses.
// Latency: 2 sync clocks + 1..2 sample periods + 1 clock; no backpressure, releases emit nothing.
module life_debounce #(
   parameter int N       = 6,
   parameter int DEB_DIV = 16384
) (
   input  logic         core_clk,
   input  logic         arst_n,
   input  logic [N-1:0] btn_n,
   output logic [N-1:0] pulse
);
   localparam int DW = $clog2(DEB_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DEB_DIV - 1);

   logic [DW-1:0] div;
   logic [N-1:0]  sync1, sync2, last_smp, stable;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         div      <= '0;
         sync1    <= '0;
         sync2    <= '0;
         last_smp <= '0;
         stable   <= '0;
         pulse    <= '0;
      end else begin
         sync1 <= ~btn_n;
         sync2 <= sync1;
         div   <= (div == DIV_LAST) ? '0 : div + 1'b1;
         pulse <= '0;
         if (div == DIV_LAST) begin
            last_smp <= sync2;
            // a key's level only moves where this sample agrees with the previous one
            stable   <= (sync2 & ~(sync2 ^ last_smp)) | (stable & (sync2 ^ last_smp));
            pulse    <= sync2 & last_smp & ~stable;
         end
      end
   end
endmodule

// File: rtl/life_ctrl.sv
// Scan timing (prescaler, cell counter, row select) and run/edit pacing for the bit-serial life core.
// nxt_bit is valid in the tick cycle of the shown cell; generations always complete a full ring.
module life_ctrl
   import life_pkg::*;
#(
   parameter int X          = 8,
   parameter int Y          = 8,
   parameter int LOG2X      = DEF_LOG2X,
   parameter int LOG2Y      = DEF_LOG2Y,
   parameter int PRESCALE   = 256,
   parameter int DEB_DIV    = 16384,
   parameter int GAP_PASSES = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             btn_n,
   output logic [LOG2X+LOG2Y-1:0] cnt,
   output logic                   nxt_bit,
   output logic [Y-1:0]           row_sel,
   output logic                   key_flip,
   output logic                   key_down,
   output logic                   key_up,
   output logic                   key_left,
   output logic                   key_right,
   output logic                   running
);
   localparam int CW = LOG2X + LOG2Y;
   localparam int PW = $clog2(PRESCALE);
   localparam int GW = (GAP_PASSES > 1) ? $clog2(GAP_PASSES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(X * Y - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PRE_PREV = PW'(PRESCALE - 2);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_PASSES - 1);

   logic [PW-1:0]       pre;
   logic                tick;
   logic                wrap;
   logic [NUM_KEYS-1:0] key_pls;
   logic                run_req;
   logic                stop_now;
   logic                edit_mode;
   state_t              state;
   logic                stop_pend;
   logic [GW-1:0]       pass_cnt;

   life_debounce #(
      .N       (NUM_KEYS),
      .DEB_DIV (DEB_DIV)
   ) u_debounce (
      .core_clk (clk),
      .arst_n   (reset),
      .btn_n    (btn_n),
      .pulse    (key_pls)
   );

   // tick is registered one count early so it lines up with pre == PRESCALE-1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre  <= '0;
         tick <= 1'b0;
         cnt  <= '0;
      end else begin
         pre  <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
         tick <= (pre == PRE_PREV);
         if (tick)
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign wrap = tick && (cnt == CNT_LAST);

   always_comb begin
      row_sel = '0;
      for (int r = 0; r < Y; r++)
         row_sel[r] = (cnt[CW-1:LOG2X] == LOG2Y'(r));
   end

   assign run_req  = key_pls[KEY_RUN];
   // a run press landing on the wrap itself toggles the pending stop before it is acted on
   assign stop_now = stop_pend ^ run_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EDIT;
         stop_pend <= 1'b0;
         pass_cnt  <= '0;
      end else begin
         case (state)
            EDIT: begin
               stop_pend <= 1'b0;
               pass_cnt  <= '0;
               if (run_req)
                  state <= ARM;
            end
            ARM: begin
               if (run_req)
                  state <= EDIT;
               else if (wrap)
                  state <= PASS;
            end
            PASS: begin
               pass_cnt <= '0;
               if (wrap) begin
                  stop_pend <= 1'b0;
                  if (stop_now)
                     state <= EDIT;
                  else if (GAP_PASSES > 0)
                     state <= GAP;
               end else if (run_req) begin
                  stop_pend <= ~stop_pend;
               end
            end
            GAP: begin
               if (wrap) begin
                  stop_pend <= 1'b0;
                  if (stop_now) begin
                     state <= EDIT;
                  end else if (pass_cnt == GAP_LAST) begin
                     pass_cnt <= '0;
                     state    <= PASS;
                  end else begin
                     pass_cnt <= pass_cnt + 1'b1;
                  end
               end else if (run_req) begin
                  stop_pend <= ~stop_pend;
               end
            end
            default: state <= EDIT;
         endcase
      end
   end

   assign edit_mode = (state == EDIT);
   assign nxt_bit   = (state == PASS) && tick;
   assign running   = !edit_mode;
   assign key_flip  = key_pls[KEY_FLIP]  && edit_mode;
   assign key_down  = key_pls[KEY_DOWN]  && edit_mode;
   assign key_up    = key_pls[KEY_UP]    && edit_mode;
   assign key_left  = key_pls[KEY_LEFT]  && edit_mode;
   assign key_right = key_pls[KEY_RIGHT] && edit_mode;
endmodule

// File: doc/life_ctrl.md
# life_ctrl

Upstream timing and control stage for the bit-serial life datapath. It produces the cell-scan counter `cnt`, the `nxt_bit` shift strobe and the one-hot display row select. It also debounces the six push-buttons into single-cycle key pulses that feed the cursor and flip logic of the life core. Its run/edit state machine paces generations as whole scan passes, so a generation never stops mid-ring.

## Interface
- `X`, 8, board width in cells
- `Y`, 8, board height in cells
- `LOG2X`, 3, clog2(X)
- `LOG2Y`, 3, clog2(Y)
- `PRESCALE`, 256, clocks per scan tick (>=2)
- `DEB_DIV`, 16384, clocks between debounce samples (>=2)
- `GAP_PASSES`, 15, idle scan passes between generations in run mode (>=0)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `btn_n`  in  6  raw buttons, active-low, asynchronous: [0] flip, [1] down, [2] up, [3] left, [4] right, [5] run
- `cnt`  out  LOG2X+LOG2Y  current cell index, 0..X*Y-1
- `nxt_bit`  out  1  shift strobe to the life core
- `row_sel`  out  Y  one-hot row select, bit cnt[LOG2X+LOG2Y-1:LOG2X]
- `key_flip`, `key_down`, `key_up`, `key_left`, `key_right`  out  1 each  one-clock key pulses
- `running`  out  1  high while not in EDIT

## Operation
- **Prescaler.** Counts 0..PRESCALE-1 and wraps. `tick` (internal, registered) is high for one clock when the prescaler equals PRESCALE-1.
- **Scan counter.** `cnt` increments on each tick and wraps from X*Y-1 to 0. `wrap` = tick && cnt==X*Y-1.
- **Debounce.**
  - 2-FF synchronizer on `btn_n`, inverted to active-high.
  - Sample all six keys every DEB_DIV clocks.
  - A key's stable level changes only when two consecutive samples agree.
  - A 0->1 transition of the stable level yields a pulse one clock wide. Releases yield nothing.
- **Key gating.**
  - Cursor/flip pulses pass to outputs only in EDIT and are forced 0 otherwise.
  - The run pulse is internal (`run_req`) and is never gated.
- **FSM states.**
  - EDIT: `nxt_bit`=0. On `run_req` go to ARM.
  - ARM: wait. On `wrap` go to PASS. On `run_req` go back to EDIT.
  - PASS: `nxt_bit` = tick. On `wrap` go to GAP if GAP_PASSES>0, else stay in PASS. Pass counter cleared.
  - GAP: `nxt_bit`=0. On `wrap`, increment the pass counter; when it reaches GAP_PASSES go to PASS.
- **Stop request.**
  - `run_req` in PASS or GAP sets `stop_pend`.
  - On the next `wrap`, PASS/GAP go to EDIT instead. This completes the pass, so exactly X*Y strobes are issued per generation.
  - A second `run_req` while `stop_pend` is set clears it (cancel).
- **Reset values.** prescaler=0, tick=0, cnt=0, `row_sel`=1, state=EDIT, `stop_pend`=0, pass counter=0, synchronizers and stable levels=0, all key pulses=0, `nxt_bit`=0, `running`=0.
- **Simultaneous events.**
  - `run_req` in the same cycle as `wrap` in PASS/GAP: the stop takes effect at that wrap (go to EDIT).
  - Key pulse in the same cycle as a transition EDIT->ARM: the pulse is still output, because gating uses the current state.

## Timing
- `nxt_bit` is combinational from registered tick and state. It is high in the tick cycle while `cnt` still shows the current cell. `cnt` advances at the end of that cycle.
- Tick period is PRESCALE clocks. The first tick after reset occurs in cycle PRESCALE-1.
- Debounce latency, raw edge to key pulse: 2 synchronizer clocks plus one to two sample periods, plus 1 clock.
- First PASS strobe after `run_req` in EDIT: at most X*Y ticks plus one tick.
- Reset mid-pass: immediate async clear. The core sees no further strobes, and the partial generation is the core's responsibility.

## Structure
- Shared package `life_pkg`: state encoding constants (EDIT, ARM, PASS, GAP), key index constants (KEY_FLIP..KEY_RUN), and the `CNT_W` = LOG2X+LOG2Y width.
- One sub-module, `life_debounce` (parameter N keys, DEB_DIV), containing the synchronizer, sampler, stable level and edge pulse logic. It is instantiated once with N=6.
- Prescaler, scan counter, row decode and FSM live in `life_ctrl`.

## Test plan
- **Reset/free-run** (PRESCALE=4, X=Y=8): release reset -> `cnt` steps every 4 clocks, wraps 63->0 after 256 clocks, `row_sel` = 8'h02 when `cnt`=8, `nxt_bit` stays 0.
- **Debounce:** bounce `btn_n[3]` 3 times within one DEB_DIV period, then hold low -> exactly one `key_left` pulse of 1 clock. Release -> no pulse.
- **Run cycle** (GAP_PASSES=2): press run at `cnt`=10 -> ARM until wrap; then 64 `nxt_bit` strobes on `cnt` 0..63, 2 silent passes, strobes again; `running`=1 throughout.
- **Stop:**
  - Press run at `cnt`=20 in PASS -> strobes continue to `cnt`=63, then EDIT; total 64 strobes that pass.
  - Second run press before the wrap -> cancel, stays running.
- **Gating:** press flip during PASS -> `key_flip` stays 0. Same press in EDIT -> one pulse.
- **Async reset mid-PASS** (`cnt`=37): assert `reset`=0 -> `cnt`=0, `nxt_bit`=0, state EDIT in the same cycle without a clock edge.
